// File: rtl/timebase_ctrl_if.sv
// Configuration/control/status bundle for timebase_ctrl.
// Optional member tick_total exists only when TIMEBASE_TICKCNT_EN is defined.
interface timebase_ctrl_if #(
  parameter int CNT_W   = 32,
  parameter int BURST_W = 8
) ();
  logic               cfg_valid;
  logic               cfg_ready;
  logic [CNT_W-1:0]   cfg_div;
  logic               cfg_oneshot;
  logic [BURST_W-1:0] cfg_burst;
  logic               start;
  logic               stop;
  logic               tick;
  logic               sq_out;
  logic               busy;
  logic               done;
`ifdef TIMEBASE_TICKCNT_EN
  logic [15:0]        tick_total;
`endif

  modport master (
`ifdef TIMEBASE_TICKCNT_EN
    input  tick_total,
`endif
    output cfg_valid, cfg_div, cfg_oneshot, cfg_burst, start, stop,
    input  cfg_ready, tick, sq_out, busy, done
  );

  modport slave (
`ifdef TIMEBASE_TICKCNT_EN
    output tick_total,
`endif
    input  cfg_valid, cfg_div, cfg_oneshot, cfg_burst, start, stop,
    output cfg_ready, tick, sq_out, busy, done
  );
endinterface

// File: rtl/timebase_ctrl.sv
// Run-time programmable timebase: divide-by-N counter producing a tick strobe
// and a square wave, periodic or one-shot burst, with a valid/ready config port.
// Optional macro TIMEBASE_TICKCNT_EN adds a 16-bit saturating tick_total count.
module timebase_ctrl #(
  parameter int          CNT_W       = 32,
  parameter int unsigned DEFAULT_DIV = 50000000,
  parameter int          BURST_W     = 8
) (
  input  logic clk,
  input  logic rst_n,
  timebase_ctrl_if.slave bus
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  // Divisors below 2 cannot produce a distinct half and terminal count.
  function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] d);
    return (d < CNT_W'(2)) ? CNT_W'(2) : d;
  endfunction

  // A burst of zero ticks is meaningless; treat it as one.
  function automatic logic [BURST_W-1:0] clamp_burst(input logic [BURST_W-1:0] b);
    return (b == '0) ? BURST_W'(1) : b;
  endfunction

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   div_q, div_d;
  logic               oneshot_q, oneshot_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BURST_W-1:0] bcnt_q, bcnt_d;
  logic               tick_q, tick_d;
  logic               sq_q, sq_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               rdy_q, rdy_d;
  logic               term_cnt, half_cnt, xfer;

  assign xfer     = bus.cfg_valid & rdy_q;
  assign term_cnt = (cnt_q == div_q - CNT_W'(1));
  assign half_cnt = (cnt_q == (div_q >> 1) - CNT_W'(1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state, counter and registered-output decode.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    oneshot_d = oneshot_q;
    burst_d   = burst_q;
    cnt_d     = cnt_q;
    bcnt_d    = bcnt_q;
    tick_d    = 1'b0;
    done_d    = 1'b0;
    sq_d      = sq_q;
    case (state_q)
      S_IDLE: begin
        if (xfer) begin
          div_d     = clamp_div(bus.cfg_div);
          oneshot_d = bus.cfg_oneshot;
          burst_d   = clamp_burst(bus.cfg_burst);
        end
        if (bus.start && !bus.stop) begin
          state_d = S_RUN;
          cnt_d   = '0;
          bcnt_d  = '0;
          sq_d    = 1'b0;
        end
      end
      S_RUN: begin
        cnt_d = term_cnt ? '0 : cnt_q + CNT_W'(1);
        if (term_cnt || half_cnt) sq_d = ~sq_q;
        if (term_cnt) begin
          tick_d = 1'b1;
          if (oneshot_q) begin
            if (bcnt_q == burst_q - BURST_W'(1)) begin
              state_d = S_IDLE;
              done_d  = !bus.stop;
            end else begin
              bcnt_d = bcnt_q + BURST_W'(1);
            end
          end
        end
        // Stop wins over everything except the final tick itself.
        if (bus.stop) state_d = S_IDLE;
        if (state_d == S_IDLE) begin
          cnt_d = '0;
          sq_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_RUN);
    rdy_d  = (state_d == S_IDLE);
  end

  // Configuration, counters and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= CNT_W'(DEFAULT_DIV);
      oneshot_q <= 1'b0;
      burst_q   <= BURST_W'(1);
      cnt_q     <= '0;
      bcnt_q    <= '0;
      tick_q    <= 1'b0;
      sq_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rdy_q     <= 1'b1;
    end else begin
      div_q     <= div_d;
      oneshot_q <= oneshot_d;
      burst_q   <= burst_d;
      cnt_q     <= cnt_d;
      bcnt_q    <= bcnt_d;
      tick_q    <= tick_d;
      sq_q      <= sq_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rdy_q     <= rdy_d;
    end
  end

  assign bus.tick      = tick_q;
  assign bus.sq_out    = sq_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.cfg_ready = rdy_q;

`ifdef TIMEBASE_TICKCNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] total_q, total_d;

  // Tick total: cleared on entry to RUN, saturating increment per tick.
  always_comb begin
    total_d = total_q;
    if (state_q == S_IDLE && state_d == S_RUN) total_d = '0;
    else if (tick_d)                           total_d = sat_inc16(total_q);
  end

  // Tick total register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) total_q <= '0;
    else        total_q <= total_d;
  end

  assign bus.tick_total = total_q;
`endif

endmodule

// File: tb/tb_timebase_ctrl.sv
// Directed bench for timebase_ctrl (DEFAULT_DIV overridden to 10).
module tb_timebase_ctrl;

  localparam int CNT_W   = 32;
  localparam int BURST_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  timebase_ctrl_if #(.CNT_W(CNT_W), .BURST_W(BURST_W)) bus ();

  timebase_ctrl #(.CNT_W(CNT_W), .DEFAULT_DIV(10), .BURST_W(BURST_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic             vld;
    logic [CNT_W-1:0] div;
    logic             os;
    logic [7:0]       burst;
    logic             start;
    logic             stop;
    logic             e_tick;
    logic             e_sq;
    logic             e_busy;
    logic             e_done;
    logic             e_rdy;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic v, input logic [CNT_W-1:0] d, input logic o,
                              input logic [7:0] b, input logic st, input logic sp,
                              input logic t, input logic s, input logic bz,
                              input logic dn, input logic r);
    vec_t x;
    x.vld = v; x.div = d; x.os = o; x.burst = b; x.start = st; x.stop = sp;
    x.e_tick = t; x.e_sq = s; x.e_busy = bz; x.e_done = dn; x.e_rdy = r;
    vecs.push_back(x);
  endfunction

  task automatic drive(input logic v, input logic [CNT_W-1:0] d, input logic o,
                       input logic [7:0] b, input logic st, input logic sp);
    bus.cfg_valid   = v;
    bus.cfg_div     = d;
    bus.cfg_oneshot = o;
    bus.cfg_burst   = b;
    bus.start       = st;
    bus.stop        = sp;
  endtask

  task automatic apply(input logic v, input logic [CNT_W-1:0] d, input logic o,
                       input logic [7:0] b, input logic st, input logic sp);
    drive(v, d, o, b, st, sp);
    @(posedge clk);
    #1;
    n_vec++;
  endtask

  task automatic chk1(input string tag, input string fld, input logic act, input logic exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s.%s: got %b expected %b", tag, fld, act, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic t, input logic s,
                            input logic bz, input logic dn, input logic r);
    chk1(tag, "tick",      bus.tick,      t);
    chk1(tag, "sq_out",    bus.sq_out,    s);
    chk1(tag, "busy",      bus.busy,      bz);
    chk1(tag, "done",      bus.done,      dn);
    chk1(tag, "cfg_ready", bus.cfg_ready, r);
  endtask

  task automatic chk_total(input string tag, input int exp);
`ifdef TIMEBASE_TICKCNT_EN
    if (bus.tick_total !== 16'(exp)) begin
      n_err++;
      $display("FAIL %s.tick_total: got %0d expected %0d", tag, bus.tick_total, exp);
    end
`else
    if (exp < 0) $display("unused %s", tag);
`endif
  endtask

  // Start with the default divisor (10), check 30 cycles of ticks, then stop.
  task automatic run_default(input string tag);
    apply(1'b0, '0, 1'b0, 8'd0, 1'b1, 1'b0);
    expect_out({tag, "_start"}, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk_total({tag, "_start"}, 0);
    for (int j = 1; j <= 30; j++) begin
      apply(1'b0, '0, 1'b0, 8'd0, 1'b0, 1'b0);
      expect_out($sformatf("%s_c%0d", tag, j), (j % 10) == 0, (j % 10) >= 5,
                 1'b1, 1'b0, 1'b0);
      chk_total($sformatf("%s_c%0d", tag, j), j / 10);
    end
    apply(1'b0, '0, 1'b0, 8'd0, 1'b0, 1'b1);
    expect_out({tag, "_stop"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_total({tag, "_stop"}, 3);
  endtask

  initial begin
    // div=4 periodic; cfg offered during RUN with start held is ignored
    add(1, 4, 0, 1, 0, 0,  0, 0, 0, 0, 1);
    add(0, 4, 0, 1, 1, 0,  0, 0, 1, 0, 0);
    add(1, 7, 1, 2, 1, 0,  0, 0, 1, 0, 0);
    add(1, 7, 1, 2, 1, 0,  0, 1, 1, 0, 0);
    add(1, 7, 1, 2, 1, 0,  0, 1, 1, 0, 0);
    add(1, 7, 1, 2, 1, 0,  1, 0, 1, 0, 0);
    add(1, 7, 1, 2, 1, 0,  0, 0, 1, 0, 0);
    add(1, 7, 1, 2, 1, 0,  0, 1, 1, 0, 0);
    add(1, 7, 1, 2, 1, 0,  0, 1, 1, 0, 0);
    add(1, 7, 1, 2, 1, 0,  1, 0, 1, 0, 0);
    add(0, 4, 0, 1, 0, 1,  0, 0, 0, 0, 1);
    // div=5 one-shot burst=3, cfg in same cycle as start
    add(1, 5, 1, 3, 1, 0,  0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1);
    // div=0, burst=0 clamp to div=2, burst=1
    add(1, 0, 1, 0, 0, 0,  0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 0,  0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1);
    // div=6 periodic, stop on terminal count; then start&stop in IDLE
    add(1, 6, 0, 1, 1, 0,  0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 1,  0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1);
    // one-shot final tick coinciding with stop: tick kept, done suppressed
    add(1, 2, 1, 1, 1, 0,  0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1);

    drive(1'b0, '0, 1'b0, 8'd0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    expect_out("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_total("reset", 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_default("dflt");

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].vld, vecs[i].div, vecs[i].os, vecs[i].burst,
            vecs[i].start, vecs[i].stop);
      expect_out($sformatf("vec%0d", i), vecs[i].e_tick, vecs[i].e_sq,
                 vecs[i].e_busy, vecs[i].e_done, vecs[i].e_rdy);
    end

    // Asynchronous reset mid-run at div=8, cnt=5
    apply(1'b1, 8, 1'b0, 8'd1, 1'b1, 1'b0);
    expect_out("mr_c0", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      apply(1'b0, '0, 1'b0, 8'd0, 1'b0, 1'b0);
      expect_out($sformatf("mr_c%0d", k), 1'b0, k >= 4, 1'b1, 1'b0, 1'b0);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    expect_out("mr_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_total("mr_reset", 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_default("post");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
